multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Moore FSM control unit for the multi-cycle RV32I datapath.
- Consumes the opcode/func3/func7 fields and the ALU zer/neg flags from the datapath.
- Drives every datapath enable and mux select, one state per cycle.
- Sits directly upstream of the datapath; the two together form the CPU core.

Parameters:
STATE_W, 4, width of state register and state_dbg port
TRAP_ON_ILLEGAL, 1, 1: unknown opcode enters sticky ILLEGAL; 0: unknown opcode returns to FETCH as a NOP

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
opcode  input  7  instruction[6:0]
func3  input  3  instruction[14:12]
func7  input  7  instruction[31:25]
zer  input  1  ALU result == 0
neg  input  1  ALU result < 0, signed
pcen  output  1  PC load enable
adrsrc  output  1  memory address select: 0 pc, 1 registered ALU out
memwrite  output  1  data memory write strobe
irwrite  output  1  IR and OLDPC load enable
regwrite  output  1  register file write enable
alusrca  output  2  ALU A select: 00 pc, 01 oldpc, 10 registered A, 11 zero
alusrcb  output  2  ALU B select: 00 registered B, 01 immediate, 10 constant 4, 11 zero
aluop  output  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
resultsrc  output  2  result select: 00 registered ALU out, 01 ALU result, 10 MDR, 11 immediate
immsrc  output  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
illegal  output  1  sticky unknown-opcode flag
state_dbg  output  STATE_W  current state encoding

Behaviour:
- Reset: rst sampled on the clk edge; state <= FETCH; illegal <= 0.
- While rst is high, pcen, memwrite, irwrite and regwrite are forced to 0. All selects are 0.
- Outputs are a pure function of the current state; the only exception is pcen in BRANCH.
- Any signal not listed for a state is 0.
- FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=add, resultsrc=01, pcen=1. PC <= PC+4. Next state DECODE.
- DECODE: alusrca=01, alusrcb=01, aluop=add. immsrc=J if opcode=1101111, else B. The registered ALU out then holds the branch/jump target.
- Next state from DECODE: lw 0000011 or sw 0100011 -> MEMADR; R-type 0110011 -> EXECR; I-ALU 0010011 -> EXECI; branch 1100011 -> BRANCH; jal 1101111 -> JAL; jalr 1100111 -> JALR; lui 0110111 -> LUI; any other opcode -> ILLEGAL (or FETCH when TRAP_ON_ILLEGAL=0).
- MEMADR: alusrca=10, alusrcb=01, aluop=add. immsrc=I for lw, S for sw. Next state MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: adrsrc=1 -> MEMWB. MDR is valid in the following cycle.
- MEMWB: resultsrc=10, regwrite=1 -> FETCH.
- MEMWRITE: adrsrc=1, memwrite=1 -> FETCH.
- EXECR: alusrca=10, alusrcb=00, aluop from the ALU decoder -> ALUWB.
- EXECI: alusrca=10, alusrcb=01, immsrc=I, aluop from the ALU decoder -> ALUWB.
- ALUWB: resultsrc=00, regwrite=1 -> FETCH.
- ALU decoder, func3 mapping: 000 add, or sub when R-type with func7[5]=1; 100 xor; 110 or; 111 and; 010 slt. Any other func3 -> illegal path, same handling as an unknown opcode.
- BRANCH: alusrca=10, alusrcb=00, aluop=sub, resultsrc=00. pcen=taken. Next state FETCH.
- Branch taken rule by func3: 000 beq: zer; 001 bne: !zer; 100 blt: neg; 101 bge: !neg. Other func3 values are never taken.
- JAL: alusrca=01, alusrcb=10, aluop=add, resultsrc=00, pcen=1. PC <= target; ALU out <= oldpc+4. Next state ALUWB.
- JALR: alusrca=10, alusrcb=01, immsrc=I, aluop=add, resultsrc=01, pcen=1 -> JALRWB. Target bit 0 is not cleared.
- JALRWB: alusrca=01, alusrcb=10, aluop=add, resultsrc=01, regwrite=1 -> FETCH.
- LUI: immsrc=U, resultsrc=11, regwrite=1 -> FETCH.
- ILLEGAL: all strobes 0; illegal=1; held until rst.
- CPI: lw 5; sw 4; R/I-type 4; jal 4; jalr 4; branch 3; lui 3.
- rst asserted mid-instruction: the partial instruction is abandoned. No write strobe fires in the reset cycle.

Decomposition:
- Shared package holds: state enum; aluop, immsrc, alusrca, alusrcb and resultsrc encodings; opcode constants.
- One sub-module, alu_decoder: combinational (opcode, func3, func7) -> aluop plus a func_illegal flag.

Test Plan:
- Reset: hold rst 2 cycles -> state_dbg=FETCH, all strobes 0, illegal=0. First post-reset cycle has irwrite=1 and pcen=1.
- add (opcode 0110011, f3 000, f7 0000000) -> states FETCH, DECODE, EXECR, ALUWB; aluop=000 in EXECR; regwrite=1 only in ALUWB. With f7 0100000 -> aluop=001.
- lw (0000011) -> 5 cycles; adrsrc=1 in MEMREAD; resultsrc=10 with regwrite in MEMWB. sw -> memwrite=1 exactly one cycle, in MEMWRITE.
- beq with zer=1 -> pcen=1 in BRANCH. bge with neg=1 -> pcen=0. Both return to FETCH after 3 cycles.
- jalr -> pcen=1 with resultsrc=01 in JALR; then regwrite=1, alusrca=01, alusrcb=10 in JALRWB.
- opcode 1111111 with TRAP_ON_ILLEGAL=1 -> ILLEGAL, illegal=1, no strobes for 10 cycles; rst clears it. With TRAP_ON_ILLEGAL=0 -> returns to FETCH after DECODE. rst asserted in MEMWRITE -> memwrite=0 and FETCH on the next cycle.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: state enum,
// datapath select encodings, opcode constants and small helper functions.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRWB   = 4'd12,
    S_LUI      = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_ALU    = 2'b01;
  localparam logic [1:0] RES_MDR    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef struct packed {
    logic       pcen;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] resultsrc;
    logic [2:0] immsrc;
  } ctrl_t;

  // Control word for a state; anything a state does not name stays 0.
  function automatic ctrl_t state_ctrl(state_t s, logic [6:0] opcode, logic [2:0] dec_aluop);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    begin c.pcen = 1'b1; c.irwrite = 1'b1; c.alusrca = SRCA_PC;
                        c.alusrcb = SRCB_FOUR; c.aluop = ALU_ADD; c.resultsrc = RES_ALU; end
      S_DECODE:   begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_IMM; c.aluop = ALU_ADD;
                        c.immsrc = (opcode == OP_JAL) ? IMM_J : IMM_B; end
      S_MEMADR:   begin c.alusrca = SRCA_REGA; c.alusrcb = SRCB_IMM; c.aluop = ALU_ADD;
                        c.immsrc = (opcode == OP_SW) ? IMM_S : IMM_I; end
      S_MEMREAD:  c.adrsrc = 1'b1;
      S_MEMWB:    begin c.resultsrc = RES_MDR; c.regwrite = 1'b1; end
      S_MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      S_EXECR:    begin c.alusrca = SRCA_REGA; c.alusrcb = SRCB_REGB; c.aluop = dec_aluop; end
      S_EXECI:    begin c.alusrca = SRCA_REGA; c.alusrcb = SRCB_IMM; c.immsrc = IMM_I;
                        c.aluop = dec_aluop; end
      S_ALUWB:    begin c.resultsrc = RES_ALUOUT; c.regwrite = 1'b1; end
      S_BRANCH:   begin c.alusrca = SRCA_REGA; c.alusrcb = SRCB_REGB; c.aluop = ALU_SUB;
                        c.resultsrc = RES_ALUOUT; end
      S_JAL:      begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_FOUR; c.aluop = ALU_ADD;
                        c.resultsrc = RES_ALUOUT; c.pcen = 1'b1; end
      S_JALR:     begin c.alusrca = SRCA_REGA; c.alusrcb = SRCB_IMM; c.immsrc = IMM_I;
                        c.aluop = ALU_ADD; c.resultsrc = RES_ALU; c.pcen = 1'b1; end
      S_JALRWB:   begin c.alusrca = SRCA_OLDPC; c.alusrcb = SRCB_FOUR; c.aluop = ALU_ADD;
                        c.resultsrc = RES_ALU; c.regwrite = 1'b1; end
      S_LUI:      begin c.immsrc = IMM_U; c.resultsrc = RES_IMM; c.regwrite = 1'b1; end
      default:    c = '0;
    endcase
    return c;
  endfunction

  // Branch condition from func3; unsupported func3 values never branch.
  function automatic logic branch_taken(logic [2:0] func3, logic zer, logic neg);
    case (func3)
      3'b000:  return zer;
      3'b001:  return !zer;
      3'b100:  return neg;
      3'b101:  return !neg;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle. There is no handshake: the datapath
// presents instruction fields and ALU flags every cycle, and the controller
// (master) drives every enable/select every cycle; the datapath (slave)
// obeys them on the next rising clock edge.
interface multicycle_controller_if #(parameter int STATE_W = 4);
  logic [6:0]         opcode;
  logic [2:0]         func3;
  logic [6:0]         func7;
  logic               zer;
  logic               neg;
  logic               pcen;
  logic               adrsrc;
  logic               memwrite;
  logic               irwrite;
  logic               regwrite;
  logic [1:0]         alusrca;
  logic [1:0]         alusrcb;
  logic [2:0]         aluop;
  logic [1:0]         resultsrc;
  logic [2:0]         immsrc;
  logic               illegal;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  opcode, func3, func7, zer, neg,
    output pcen, adrsrc, memwrite, irwrite, regwrite, alusrca, alusrcb,
           aluop, resultsrc, immsrc, illegal, state_dbg
  );

  modport slave (
    output opcode, func3, func7, zer, neg,
    input  pcen, adrsrc, memwrite, irwrite, regwrite, alusrca, alusrcb,
           aluop, resultsrc, immsrc, illegal, state_dbg
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU decoder: maps func3/func7 of R- and I-type instructions to an ALU
// operation and flags func3 values this core does not implement.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_func3,
  input  logic [6:0] i_func7,
  output logic [2:0] o_aluop,
  output logic       o_func_illegal
);

  // Only func7[5] selects anything (sub vs add); the other bits are don't-care.
  logic w_unused_func7;
  assign w_unused_func7 = ^{i_func7[6], i_func7[4:0]};

  // func3 decode for arithmetic opcodes; other opcodes get add and no flag.
  always_comb begin
    o_aluop        = ALU_ADD;
    o_func_illegal = 1'b0;
    if (i_opcode == OP_R || i_opcode == OP_I) begin
      case (i_func3)
        3'b000:  o_aluop = (i_opcode == OP_R && i_func7[5]) ? ALU_SUB : ALU_ADD;
        3'b100:  o_aluop = ALU_XOR;
        3'b110:  o_aluop = ALU_OR;
        3'b111:  o_aluop = ALU_AND;
        3'b010:  o_aluop = ALU_SLT;
        default: o_func_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle RV32I datapath. The control word is
// registered alongside the state; only DECODE's immsrc (the IR is loaded at
// the end of FETCH) and BRANCH's pcen (needs live ALU flags) are combinational.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int STATE_W         = 4,
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  localparam state_t ILLEGAL_DEST = TRAP_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;

  state_t     r_state;
  state_t     w_next;
  ctrl_t      r_ctrl;
  ctrl_t      w_ctrl;
  logic       r_illegal;
  logic [2:0] w_dec_aluop;
  logic       w_func_illegal;

  multicycle_controller_alu_decoder u_alu_decoder (
    .i_opcode       (bus.opcode),
    .i_func3        (bus.func3),
    .i_func7        (bus.func7),
    .o_aluop        (w_dec_aluop),
    .o_func_illegal (w_func_illegal)
  );

  // Next-state selection; opcode dispatch happens only in DECODE.
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = w_func_illegal ? ILLEGAL_DEST : S_EXECR;
          OP_I:         w_next = w_func_illegal ? ILLEGAL_DEST : S_EXECI;
          OP_BR:        w_next = S_BRANCH;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_JALR;
          OP_LUI:       w_next = S_LUI;
          default:      w_next = ILLEGAL_DEST;
        endcase
      end
      S_MEMADR:   w_next = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECR,
      S_EXECI,
      S_JAL:      w_next = S_ALUWB;
      S_JALR:     w_next = S_JALRWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  // State, registered control word for the state being entered, sticky trap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ctrl    <= state_ctrl(S_FETCH, 7'd0, ALU_ADD);
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= state_ctrl(w_next, bus.opcode, w_dec_aluop);
      if (w_next == S_ILLEGAL) r_illegal <= 1'b1;
    end
  end

  // Live overrides, then everything forced quiet while reset is held.
  always_comb begin
    w_ctrl = r_ctrl;
    if (r_state == S_DECODE) w_ctrl.immsrc = (bus.opcode == OP_JAL) ? IMM_J : IMM_B;
    if (r_state == S_BRANCH) w_ctrl.pcen = branch_taken(bus.func3, bus.zer, bus.neg);
    if (rst) w_ctrl = '0;
  end

  assign bus.pcen      = w_ctrl.pcen;
  assign bus.adrsrc    = w_ctrl.adrsrc;
  assign bus.memwrite  = w_ctrl.memwrite;
  assign bus.irwrite   = w_ctrl.irwrite;
  assign bus.regwrite  = w_ctrl.regwrite;
  assign bus.alusrca   = w_ctrl.alusrca;
  assign bus.alusrcb   = w_ctrl.alusrcb;
  assign bus.aluop     = w_ctrl.aluop;
  assign bus.resultsrc = w_ctrl.resultsrc;
  assign bus.immsrc    = w_ctrl.immsrc;
  assign bus.illegal   = r_illegal;
  assign bus.state_dbg = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle vector table for every
// instruction class, then hand sequences for trap, reset and abort cases.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  multicycle_controller_if #(.STATE_W(4)) if1 ();
  multicycle_controller_if #(.STATE_W(4)) if0 ();

  multicycle_controller #(.STATE_W(4), .TRAP_ON_ILLEGAL(1'b1)) dut1 (
    .clk (clk), .rst (rst), .bus (if1)
  );
  multicycle_controller #(.STATE_W(4), .TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk (clk), .rst (rst), .bus (if0)
  );

  assign if0.opcode = if1.opcode;
  assign if0.func3  = if1.func3;
  assign if0.func7  = if1.func7;
  assign if0.zer    = if1.zer;
  assign if0.neg    = if1.neg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // control word packing: {pcen,adrsrc,memwrite,irwrite,regwrite,asa,asb,aluop,res,imm}
  wire [16:0] act1 = {if1.pcen, if1.adrsrc, if1.memwrite, if1.irwrite, if1.regwrite,
                      if1.alusrca, if1.alusrcb, if1.aluop, if1.resultsrc, if1.immsrc};
  wire [16:0] act0 = {if0.pcen, if0.adrsrc, if0.memwrite, if0.irwrite, if0.regwrite,
                      if0.alusrca, if0.alusrcb, if0.aluop, if0.resultsrc, if0.immsrc};
  wire [3:0]  strobes1 = {if1.pcen, if1.memwrite, if1.irwrite, if1.regwrite};

  function automatic logic [16:0] c(input logic pcen, adr, mw, irw, rw,
                                    input logic [1:0] asa, asb, input logic [2:0] op,
                                    input logic [1:0] rs, input logic [2:0] imm);
    return {pcen, adr, mw, irw, rw, asa, asb, op, rs, imm};
  endfunction

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        zer;
    logic        neg;
    logic [3:0]  st;
    logic [16:0] ctrl;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic add(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                     input logic zer, input logic neg, input logic [3:0] st,
                     input logic [16:0] ctrl);
    vec_t v;
    v.op = op; v.f3 = f3; v.f7 = f7; v.zer = zer; v.neg = neg; v.st = st; v.ctrl = ctrl;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic zer, input logic neg);
    if1.opcode = op; if1.func3 = f3; if1.func7 = f7; if1.zer = zer; if1.neg = neg;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  logic [16:0] C_FETCH, C_DEC_B, C_DEC_J, C_ALUWB;

  initial begin
    C_FETCH = c(1,0,0,1,0, 2'd0,2'd2,3'd0,2'd1,3'd0);
    C_DEC_B = c(0,0,0,0,0, 2'd1,2'd1,3'd0,2'd0,3'd2);
    C_DEC_J = c(0,0,0,0,0, 2'd1,2'd1,3'd0,2'd0,3'd3);
    C_ALUWB = c(0,0,0,0,1, 2'd0,2'd0,3'd0,2'd0,3'd0);

    // add, sub, or, slt (R-type)
    add(7'b0110011,3'b000,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b0110011,3'b000,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b0110011,3'b000,7'b0000000,0,0, 4'd6, c(0,0,0,0,0,2'd2,2'd0,3'd0,2'd0,3'd0));
    add(7'b0110011,3'b000,7'b0000000,0,0, 4'd8, C_ALUWB);
    add(7'b0110011,3'b000,7'b0100000,0,0, 4'd0, C_FETCH);
    add(7'b0110011,3'b000,7'b0100000,0,0, 4'd1, C_DEC_B);
    add(7'b0110011,3'b000,7'b0100000,0,0, 4'd6, c(0,0,0,0,0,2'd2,2'd0,3'd1,2'd0,3'd0));
    add(7'b0110011,3'b000,7'b0100000,0,0, 4'd8, C_ALUWB);
    add(7'b0110011,3'b110,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b0110011,3'b110,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b0110011,3'b110,7'b0000000,0,0, 4'd6, c(0,0,0,0,0,2'd2,2'd0,3'd3,2'd0,3'd0));
    add(7'b0110011,3'b110,7'b0000000,0,0, 4'd8, C_ALUWB);
    add(7'b0110011,3'b010,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b0110011,3'b010,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b0110011,3'b010,7'b0000000,0,0, 4'd6, c(0,0,0,0,0,2'd2,2'd0,3'd5,2'd0,3'd0));
    add(7'b0110011,3'b010,7'b0000000,0,0, 4'd8, C_ALUWB);
    // xori, andi, addi with imm bit 30 set (must stay add)
    add(7'b0010011,3'b100,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b0010011,3'b100,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b0010011,3'b100,7'b0000000,0,0, 4'd7, c(0,0,0,0,0,2'd2,2'd1,3'd4,2'd0,3'd0));
    add(7'b0010011,3'b100,7'b0000000,0,0, 4'd8, C_ALUWB);
    add(7'b0010011,3'b111,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b0010011,3'b111,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b0010011,3'b111,7'b0000000,0,0, 4'd7, c(0,0,0,0,0,2'd2,2'd1,3'd2,2'd0,3'd0));
    add(7'b0010011,3'b111,7'b0000000,0,0, 4'd8, C_ALUWB);
    add(7'b0010011,3'b000,7'b0100000,0,0, 4'd0, C_FETCH);
    add(7'b0010011,3'b000,7'b0100000,0,0, 4'd1, C_DEC_B);
    add(7'b0010011,3'b000,7'b0100000,0,0, 4'd7, c(0,0,0,0,0,2'd2,2'd1,3'd0,2'd0,3'd0));
    add(7'b0010011,3'b000,7'b0100000,0,0, 4'd8, C_ALUWB);
    // lw (5 cycles), sw (4 cycles)
    add(7'b0000011,3'b010,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b0000011,3'b010,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b0000011,3'b010,7'b0000000,0,0, 4'd2, c(0,0,0,0,0,2'd2,2'd1,3'd0,2'd0,3'd0));
    add(7'b0000011,3'b010,7'b0000000,0,0, 4'd3, c(0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,3'd0));
    add(7'b0000011,3'b010,7'b0000000,0,0, 4'd4, c(0,0,0,0,1,2'd0,2'd0,3'd0,2'd2,3'd0));
    add(7'b0100011,3'b010,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b0100011,3'b010,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b0100011,3'b010,7'b0000000,0,0, 4'd2, c(0,0,0,0,0,2'd2,2'd1,3'd0,2'd0,3'd1));
    add(7'b0100011,3'b010,7'b0000000,0,0, 4'd5, c(0,1,1,0,0,2'd0,2'd0,3'd0,2'd0,3'd0));
    // branches: beq taken, bge not taken, bne taken, blt not taken
    add(7'b1100011,3'b000,7'b0000000,1,0, 4'd0, C_FETCH);
    add(7'b1100011,3'b000,7'b0000000,1,0, 4'd1, C_DEC_B);
    add(7'b1100011,3'b000,7'b0000000,1,0, 4'd9, c(1,0,0,0,0,2'd2,2'd0,3'd1,2'd0,3'd0));
    add(7'b1100011,3'b101,7'b0000000,0,1, 4'd0, C_FETCH);
    add(7'b1100011,3'b101,7'b0000000,0,1, 4'd1, C_DEC_B);
    add(7'b1100011,3'b101,7'b0000000,0,1, 4'd9, c(0,0,0,0,0,2'd2,2'd0,3'd1,2'd0,3'd0));
    add(7'b1100011,3'b001,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b1100011,3'b001,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b1100011,3'b001,7'b0000000,0,0, 4'd9, c(1,0,0,0,0,2'd2,2'd0,3'd1,2'd0,3'd0));
    add(7'b1100011,3'b100,7'b0000000,1,0, 4'd0, C_FETCH);
    add(7'b1100011,3'b100,7'b0000000,1,0, 4'd1, C_DEC_B);
    add(7'b1100011,3'b100,7'b0000000,1,0, 4'd9, c(0,0,0,0,0,2'd2,2'd0,3'd1,2'd0,3'd0));
    // jal, jalr, lui
    add(7'b1101111,3'b000,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b1101111,3'b000,7'b0000000,0,0, 4'd1, C_DEC_J);
    add(7'b1101111,3'b000,7'b0000000,0,0, 4'd10, c(1,0,0,0,0,2'd1,2'd2,3'd0,2'd0,3'd0));
    add(7'b1101111,3'b000,7'b0000000,0,0, 4'd8, C_ALUWB);
    add(7'b1100111,3'b000,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b1100111,3'b000,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b1100111,3'b000,7'b0000000,0,0, 4'd11, c(1,0,0,0,0,2'd2,2'd1,3'd0,2'd1,3'd0));
    add(7'b1100111,3'b000,7'b0000000,0,0, 4'd12, c(0,0,0,0,1,2'd1,2'd2,3'd0,2'd1,3'd0));
    add(7'b0110111,3'b000,7'b0000000,0,0, 4'd0, C_FETCH);
    add(7'b0110111,3'b000,7'b0000000,0,0, 4'd1, C_DEC_B);
    add(7'b0110111,3'b000,7'b0000000,0,0, 4'd13, c(0,0,0,0,1,2'd0,2'd0,3'd0,2'd3,3'd4));

    // ---- reset: held 2 cycles ----
    drive(7'd0, 3'd0, 7'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(if1.state_dbg), 32'd0);
    chk("rst_ctrl", 32'(act1), 32'd0);
    chk("rst_illegal", 32'(if1.illegal), 32'd0);
    chk("rst_state_nt", 32'(if0.state_dbg), 32'd0);
    rst = 1'b0;

    // ---- table: one row per cycle ----
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].zer, vecs[i].neg);
      #1;
      chk($sformatf("row%0d_state", i), 32'(if1.state_dbg), 32'(vecs[i].st));
      chk($sformatf("row%0d_ctrl", i), 32'(act1), 32'(vecs[i].ctrl));
      chk($sformatf("row%0d_illegal", i), 32'(if1.illegal), 32'd0);
      @(negedge clk);
    end

    // ---- unknown opcode: trap vs NOP ----
    drive(7'b1111111, 3'd0, 7'd0, 1'b0, 1'b0);
    #1;
    chk("ill_fetch", 32'(if1.state_dbg), 32'd0);
    @(negedge clk);
    chk("ill_decode", 32'(if1.state_dbg), 32'd1);
    chk("ill_decode_nt", 32'(if0.state_dbg), 32'd1);
    @(negedge clk);
    chk("ill_state", 32'(if1.state_dbg), 32'd14);
    chk("ill_flag", 32'(if1.illegal), 32'd1);
    chk("ill_ctrl", 32'(act1), 32'd0);
    chk("nop_state_nt", 32'(if0.state_dbg), 32'd0);
    chk("nop_ctrl_nt", 32'(act0), 32'(C_FETCH));
    chk("nop_flag_nt", 32'(if0.illegal), 32'd0);
    drive(7'b0110011, 3'd0, 7'd0, 1'b1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("ill_hold%0d_state", k), 32'(if1.state_dbg), 32'd14);
      chk($sformatf("ill_hold%0d_strobes", k), 32'(strobes1), 32'd0);
      chk($sformatf("ill_hold%0d_flag", k), 32'(if1.illegal), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("ill_rst_state", 32'(if1.state_dbg), 32'd0);
    chk("ill_rst_flag", 32'(if1.illegal), 32'd0);
    chk("ill_rst_ctrl", 32'(act1), 32'd0);
    rst = 1'b0;

    // ---- unsupported func3 on R-type takes the same path ----
    drive(7'b0110011, 3'b001, 7'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("fill_decode", 32'(if1.state_dbg), 32'd1);
    @(negedge clk);
    chk("fill_state", 32'(if1.state_dbg), 32'd14);
    chk("fill_flag", 32'(if1.illegal), 32'd1);
    chk("fill_state_nt", 32'(if0.state_dbg), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // ---- reset during MEMWRITE abandons the store ----
    drive(7'b0100011, 3'b010, 7'd0, 1'b0, 1'b0);
    #1;
    chk("abort_fetch", 32'(if1.state_dbg), 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_memwrite_state", 32'(if1.state_dbg), 32'd5);
    chk("abort_memwrite_on", 32'(if1.memwrite), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_rst_memwrite", 32'(if1.memwrite), 32'd0);
    chk("abort_rst_ctrl", 32'(act1), 32'd0);
    @(negedge clk);
    chk("abort_after_state", 32'(if1.state_dbg), 32'd0);
    chk("abort_after_memwrite", 32'(if1.memwrite), 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_refetch_ctrl", 32'(act1), 32'(C_FETCH));

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
